// File: rtl/sigmoid_pwl_pipe.sv
// Three-stage fixed-point sigmoid using a four-segment piecewise-linear fit (shifts and adds only).
// Stage 1 takes the sign and magnitude, stage 2 evaluates the segment, stage 3 restores the sign.
module sigmoid_pwl_pipe #(
    parameter int unsigned W    = 17,
    parameter int unsigned FRAC = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_y
);

    localparam logic [W-1:0] One     = W'(1) << FRAC;
    localparam logic [W-1:0] Half    = W'(1) << (FRAC - 1);
    localparam logic [W-1:0] Thr5    = W'(5) << FRAC;          // 5.0
    localparam logic [W-1:0] Thr2375 = W'(19) << (FRAC - 3);   // 2.375
    localparam logic [W-1:0] CHi     = W'(27) << (FRAC - 5);   // 0.84375
    localparam logic [W-1:0] CMid    = W'(5) << (FRAC - 3);    // 0.625
    localparam logic [W-1:0] MinNeg  = W'(1) << (W - 1);
    localparam logic [W-1:0] MaxMag  = MinNeg - W'(1);

    logic         adv;

    logic         v1_q, v1_d;
    logic         s1_q, s1_d;
    logic [W-1:0] a1_q, a1_d;

    logic         v2_q, v2_d;
    logic         s2_q, s2_d;
    logic [W-1:0] p2_q, p2_d;

    logic         v3_q, v3_d;
    logic [W-1:0] y3_q, y3_d;

    // A single enable moves every stage, so a stalled output freezes the whole pipe.
    always_comb begin
        adv = !v3_q || out_ready;
    end

    always_comb begin
        v1_d = v1_q;
        s1_d = s1_q;
        a1_d = a1_q;
        v2_d = v2_q;
        s2_d = s2_q;
        p2_d = p2_q;
        v3_d = v3_q;
        y3_d = y3_q;

        if (adv) begin
            v1_d = in_valid;
            s1_d = in_x[W-1];
            if (in_x == MinNeg) begin
                a1_d = MaxMag;
            end else if (in_x[W-1]) begin
                a1_d = -in_x;
            end else begin
                a1_d = in_x;
            end

            v2_d = v1_q;
            s2_d = s1_q;
            if (a1_q >= Thr5) begin
                p2_d = One;
            end else if (a1_q >= Thr2375) begin
                p2_d = (a1_q >> 5) + CHi;
            end else if (a1_q >= One) begin
                p2_d = (a1_q >> 3) + CMid;
            end else begin
                p2_d = (a1_q >> 2) + Half;
            end

            // p never exceeds 1.0, so the reflection cannot underflow.
            v3_d = v2_q;
            y3_d = s2_q ? (One - p2_q) : p2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            s1_q <= 1'b0;
            a1_q <= '0;
            v2_q <= 1'b0;
            s2_q <= 1'b0;
            p2_q <= '0;
            v3_q <= 1'b0;
            y3_q <= '0;
        end else begin
            v1_q <= v1_d;
            s1_q <= s1_d;
            a1_q <= a1_d;
            v2_q <= v2_d;
            s2_q <= s2_d;
            p2_q <= p2_d;
            v3_q <= v3_d;
            y3_q <= y3_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign out_y     = y3_q;

endmodule
